// File: rtl/regfile_ft.sv
// regfile_ft: multi-port register file with one even-parity bit per entry,
// a fault-injection FSM (overlay or committed upset) and a background
// scrubber that reports stored-data parity mismatches.
module regfile_ft #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREAD = 2,
   parameter int ADDRW = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [ADDRW-1:0]       waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [NREAD*ADDRW-1:0] raddr,
   output logic [NREAD*WIDTH-1:0] rdata,
   output logic [NREAD-1:0]       rperr,
   input  logic                   fi_valid,
   output logic                   fi_ready,
   input  logic [ADDRW-1:0]       fi_addr,
   input  logic [WIDTH-1:0]       fi_mask,
   input  logic [1:0]             fi_type,
   input  logic [1:0]             fi_mode,
   input  logic [15:0]            fi_dur,
   output logic                   fault_active,
   input  logic                   scrub_en,
   output logic                   scrub_err,
   output logic [ADDRW-1:0]       scrub_err_addr,
   output logic [15:0]            scrub_err_cnt
);

   localparam logic [ADDRW-1:0] LAST_ADDR  = ADDRW'(DEPTH - 1);
   localparam logic [ADDRW-1:0] FIRST_ADDR = ADDRW'(1);
   localparam logic [1:0]       TYPE_CLEAR = 2'd0;
   localparam logic [1:0]       MODE_TRANS = 2'd1;
   localparam logic [1:0]       MODE_UPSET = 2'd2;

   typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

   state_t           state_reg, state_next;
   logic [ADDRW-1:0] fa_addr_reg, fa_addr_next;
   logic [WIDTH-1:0] fa_mask_reg, fa_mask_next;
   logic [1:0]       fa_type_reg, fa_type_next;
   logic [15:0]      cnt_reg, cnt_next;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] par;

   logic [ADDRW-1:0] scrub_ptr_reg;
   logic             scrub_mismatch;
   logic             scrub_skip;
   logic             commit_en;
   logic             fi_accept;

   // Corrupt a value with a mask according to the fault type.
   function automatic logic [WIDTH-1:0] apply_fault(input logic [WIDTH-1:0] value,
                                                    input logic [WIDTH-1:0] mask,
                                                    input logic [1:0]       ftype);
      logic [WIDTH-1:0] result;
      case (ftype)
         2'd1:    result = value ^ mask;
         2'd2:    result = value & ~mask;
         2'd3:    result = value | mask;
         default: result = value;
      endcase
      return result;
   endfunction

   assign fi_ready     = (state_reg != COMMIT);
   assign fi_accept    = fi_valid && fi_ready;
   assign fault_active = (state_reg == ACTIVE);

   // A host write to the upset target wins; the upset is then discarded.
   assign commit_en = (state_reg == COMMIT) && (fa_addr_reg != '0) &&
                      !(we && (waddr == fa_addr_reg));

   // Fault FSM state register; reset aborts any pending overlay or upset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         fa_addr_reg <= '0;
         fa_mask_reg <= '0;
         fa_type_reg <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         fa_addr_reg <= fa_addr_next;
         fa_mask_reg <= fa_mask_next;
         fa_type_reg <= fa_type_next;
         cnt_reg     <= cnt_next;
      end
   end

   // Next-state: transient expiry, one-cycle commit, then request acceptance.
   // A count of zero while ACTIVE means a permanent overlay.
   always_comb begin
      state_next   = state_reg;
      fa_addr_next = fa_addr_reg;
      fa_mask_next = fa_mask_reg;
      fa_type_next = fa_type_reg;
      cnt_next     = cnt_reg;
      case (state_reg)
         ACTIVE: begin
            if (cnt_reg == 16'd1) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg != 16'd0) begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
         COMMIT:  state_next = IDLE;
         default: ;
      endcase
      if (fi_accept) begin
         if (fi_type == TYPE_CLEAR) begin
            state_next = IDLE;
            cnt_next   = '0;
         end else begin
            fa_addr_next = fi_addr;
            fa_mask_next = fi_mask;
            fa_type_next = fi_type;
            if (fi_mode == MODE_UPSET) begin
               state_next = COMMIT;
               cnt_next   = '0;
            end else begin
               state_next = ACTIVE;
               if (fi_mode == MODE_TRANS)
                  cnt_next = (fi_dur == 16'd0) ? 16'd1 : fi_dur;
               else
                  cnt_next = '0;
            end
         end
      end
   end

   // Storage: host writes update data and parity; an upset corrupts data only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         par <= '0;
      end else begin
         if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
            par[waddr] <= ^wdata;
         end
         if (commit_en)
            mem[fa_addr_reg] <= apply_fault(mem[fa_addr_reg], fa_mask_reg, fa_type_reg);
      end
   end

   // Scrubber compares raw stored data to stored parity; overlays are invisible here.
   assign scrub_mismatch = (^mem[scrub_ptr_reg]) ^ par[scrub_ptr_reg];
   assign scrub_skip     = (we && (waddr == scrub_ptr_reg)) ||
                           ((state_reg == COMMIT) && (fa_addr_reg == scrub_ptr_reg));

   // Scrub pointer sweep over 1..DEPTH-1 with error pulse and saturating count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scrub_ptr_reg  <= FIRST_ADDR;
         scrub_err      <= 1'b0;
         scrub_err_addr <= '0;
         scrub_err_cnt  <= '0;
      end else begin
         scrub_err <= 1'b0;
         if (scrub_en) begin
            scrub_ptr_reg <= (scrub_ptr_reg == LAST_ADDR) ? FIRST_ADDR : scrub_ptr_reg + FIRST_ADDR;
            if (scrub_mismatch && !scrub_skip) begin
               scrub_err      <= 1'b1;
               scrub_err_addr <= scrub_ptr_reg;
               if (scrub_err_cnt != 16'hFFFF)
                  scrub_err_cnt <= scrub_err_cnt + 16'd1;
            end
         end
      end
   end

   // Combinational read ports: write bypass, then overlay, then r0 forced to zero.
   genvar gi;
   generate
      for (gi = 0; gi < NREAD; gi++) begin : g_read
         logic [ADDRW-1:0] ra;
         logic             bypass;
         logic [WIDTH-1:0] pre_data;
         logic             pre_par;
         logic [WIDTH-1:0] post_data;
         assign ra        = raddr[gi*ADDRW +: ADDRW];
         assign bypass    = we && (waddr == ra);
         assign pre_data  = bypass ? wdata : mem[ra];
         assign pre_par   = bypass ? ^wdata : par[ra];
         assign post_data = (fault_active && (fa_addr_reg == ra)) ?
                            apply_fault(pre_data, fa_mask_reg, fa_type_reg) : pre_data;
         assign rdata[gi*WIDTH +: WIDTH] = (ra == '0) ? '0 : post_data;
         assign rperr[gi] = (ra == '0) ? 1'b0 : ((^post_data) ^ pre_par);
      end
   endgenerate

endmodule

// File: tb/tb_regfile_ft.sv
// tb_regfile_ft: directed scenarios plus randomized traffic for regfile_ft,
// checked every cycle against a behavioural model of the register file.
module tb_regfile_ft;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int NREAD = 2;
   localparam int ADDRW = 5;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   we;
   logic [ADDRW-1:0]       waddr;
   logic [WIDTH-1:0]       wdata;
   logic [NREAD*ADDRW-1:0] raddr;
   logic [NREAD*WIDTH-1:0] rdata;
   logic [NREAD-1:0]       rperr;
   logic                   fi_valid;
   logic                   fi_ready;
   logic [ADDRW-1:0]       fi_addr;
   logic [WIDTH-1:0]       fi_mask;
   logic [1:0]             fi_type;
   logic [1:0]             fi_mode;
   logic [15:0]            fi_dur;
   logic                   fault_active;
   logic                   scrub_en;
   logic                   scrub_err;
   logic [ADDRW-1:0]       scrub_err_addr;
   logic [15:0]            scrub_err_cnt;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [WIDTH-1:0] m_mem [DEPTH];
   logic             m_par [DEPTH];
   logic             m_active;
   logic             m_commit;
   int               m_remaining;
   logic [ADDRW-1:0] m_faddr;
   logic [WIDTH-1:0] m_fmask;
   logic [1:0]       m_ftype;
   logic [ADDRW-1:0] m_ptr;
   logic             m_serr;
   logic [ADDRW-1:0] m_serr_addr;
   logic [15:0]      m_serr_cnt;

   always #5 clk = ~clk;

   regfile_ft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .ADDRW(ADDRW)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rperr(rperr),
      .fi_valid(fi_valid), .fi_ready(fi_ready), .fi_addr(fi_addr), .fi_mask(fi_mask),
      .fi_type(fi_type), .fi_mode(fi_mode), .fi_dur(fi_dur), .fault_active(fault_active),
      .scrub_en(scrub_en), .scrub_err(scrub_err), .scrub_err_addr(scrub_err_addr),
      .scrub_err_cnt(scrub_err_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic parity_of(input logic [WIDTH-1:0] v);
      return ($countones(v) % 2) == 1;
   endfunction

   // Bit-by-bit corruption: each masked bit is inverted, cleared or set.
   function automatic logic [WIDTH-1:0] corrupt(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] m,
                                                input logic [1:0] t);
      logic [WIDTH-1:0] r;
      r = v;
      for (int b = 0; b < WIDTH; b++) begin
         if (m[b]) begin
            case (t)
               2'd1:    r[b] = ~v[b];
               2'd2:    r[b] = 1'b0;
               2'd3:    r[b] = 1'b1;
               default: ;
            endcase
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_par[i] = 1'b0;
      end
      m_active    = 1'b0;
      m_commit    = 1'b0;
      m_remaining = 0;
      m_faddr     = '0;
      m_fmask     = '0;
      m_ftype     = '0;
      m_ptr       = ADDRW'(1);
      m_serr      = 1'b0;
      m_serr_addr = '0;
      m_serr_cnt  = '0;
   endtask

   task automatic expect_read(input logic [ADDRW-1:0] ra, output logic [WIDTH-1:0] ev,
                              output logic ep);
      logic [WIDTH-1:0] val;
      logic             sp;
      if (ra == '0) begin
         ev = '0;
         ep = 1'b0;
         return;
      end
      if (we && waddr == ra) begin
         val = wdata;
         sp  = parity_of(wdata);
      end else begin
         val = m_mem[ra];
         sp  = m_par[ra];
      end
      if (m_active && m_faddr == ra) val = corrupt(val, m_fmask, m_ftype);
      ev = val;
      ep = parity_of(val) ^ sp;
   endtask

   task automatic compare_all();
      logic [WIDTH-1:0] ev;
      logic             ep;
      logic [ADDRW-1:0] ra;
      for (int p = 0; p < NREAD; p++) begin
         ra = raddr[p*ADDRW +: ADDRW];
         expect_read(ra, ev, ep);
         check($sformatf("rdata%0d@r%0d", p, ra), 64'(rdata[p*WIDTH +: WIDTH]), 64'(ev));
         check($sformatf("rperr%0d@r%0d", p, ra), 64'(rperr[p]), 64'(ep));
      end
      check("fault_active", 64'(fault_active), 64'(m_active));
      check("fi_ready", 64'(fi_ready), 64'(!m_commit));
      check("scrub_err", 64'(scrub_err), 64'(m_serr));
      check("scrub_err_addr", 64'(scrub_err_addr), 64'(m_serr_addr));
      check("scrub_err_cnt", 64'(scrub_err_cnt), 64'(m_serr_cnt));
   endtask

   // Advance the model across one rising edge using the inputs held this cycle.
   task automatic model_edge();
      logic accept;
      if (!rst_n) begin
         model_reset();
         return;
      end
      accept = fi_valid && !m_commit;
      m_serr = 1'b0;
      if (scrub_en) begin
         if ((parity_of(m_mem[m_ptr]) != m_par[m_ptr]) && !(we && waddr == m_ptr) &&
             !(m_commit && m_faddr == m_ptr)) begin
            m_serr      = 1'b1;
            m_serr_addr = m_ptr;
            if (m_serr_cnt != 16'hFFFF) m_serr_cnt = m_serr_cnt + 16'd1;
         end
         m_ptr = (m_ptr == ADDRW'(DEPTH - 1)) ? ADDRW'(1) : m_ptr + ADDRW'(1);
      end
      if (m_commit && m_faddr != '0 && !(we && waddr == m_faddr))
         m_mem[m_faddr] = corrupt(m_mem[m_faddr], m_fmask, m_ftype);
      if (we && waddr != '0) begin
         m_mem[waddr] = wdata;
         m_par[waddr] = parity_of(wdata);
      end
      if (m_commit) begin
         m_commit = 1'b0;
      end else if (m_active && m_remaining > 0) begin
         m_remaining--;
         if (m_remaining == 0) m_active = 1'b0;
      end
      if (accept) begin
         if (fi_type == 2'd0) begin
            m_active = 1'b0;
         end else begin
            m_faddr = fi_addr;
            m_fmask = fi_mask;
            m_ftype = fi_type;
            if (fi_mode == 2'd2) begin
               m_active = 1'b0;
               m_commit = 1'b1;
            end else begin
               m_active    = 1'b1;
               m_remaining = (fi_mode == 2'd1) ? ((fi_dur == 16'd0) ? 1 : int'(fi_dur)) : -1;
            end
         end
      end
   endtask

   // One clock cycle: compare, step the model at the edge, return at the negedge.
   task automatic cycle();
      #1;
      $display("cyc t=%0t rst_n=%0b we=%0b wa=%0d wd=%h ra=%h fi=%0b/%0d/%0d fa=%0b", $time,
               rst_n, we, waddr, wdata, raddr, fi_valid, fi_type, fi_mode, fault_active);
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
      raddr    = '0;
      fi_valid = 1'b0;
      fi_addr  = '0;
      fi_mask  = '0;
      fi_type  = '0;
      fi_mode  = '0;
      fi_dur   = '0;
      scrub_en = 1'b0;
   endtask

   task automatic set_raddr(input logic [ADDRW-1:0] a0, input logic [ADDRW-1:0] a1);
      raddr = {a1, a0};
   endtask

   function automatic logic [ADDRW-1:0] rand_addr();
      if ($urandom_range(0, 3) != 0) return ADDRW'($urandom_range(0, 7));
      return ADDRW'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      int n;
      logic [15:0] base;
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      set_raddr(5, 6);
      #1;
      check("reset_rdata", 64'(rdata), 64'(0));
      check("reset_fi_ready", 64'(fi_ready), 64'(1));
      check("reset_cnt", 64'(scrub_err_cnt), 64'(0));
      cycle();
      rst_n = 1'b1;

      // Write r5 and read it back on both ports; then same-cycle bypass of r6.
      we = 1'b1; waddr = 5; wdata = 32'h0000_00FF; set_raddr(5, 5);
      cycle();
      we = 1'b0;
      #1;
      check("r5_read", 64'(rdata), {32'h0000_00FF, 32'h0000_00FF});
      check("r5_rperr", 64'(rperr), 64'(0));
      cycle();
      we = 1'b1; waddr = 6; wdata = 32'h0000_1234; set_raddr(6, 6);
      #1;
      check("r6_bypass", 64'(rdata), {32'h0000_1234, 32'h0000_1234});
      cycle();
      we = 1'b0;

      // Permanent flip overlay on r5, then cleared by a type-0 request.
      fi_valid = 1'b1; fi_addr = 5; fi_mask = 32'h1; fi_type = 2'd1; fi_mode = 2'd0;
      set_raddr(5, 5);
      cycle();
      fi_valid = 1'b0;
      #1;
      check("perm_rdata", 64'(rdata[31:0]), 64'h0000_00FE);
      check("perm_rperr", 64'(rperr), 64'(2'b11));
      check("perm_active", 64'(fault_active), 64'(1));
      cycle();
      fi_valid = 1'b1; fi_type = 2'd0;
      cycle();
      fi_valid = 1'b0;
      #1;
      check("clear_rdata", 64'(rdata[31:0]), 64'h0000_00FF);
      check("clear_rperr", 64'(rperr), 64'(0));
      cycle();

      // Transient stuck-1 overlay lasting 3 cycles.
      fi_valid = 1'b1; fi_type = 2'd3; fi_mode = 2'd1; fi_mask = 32'h8000_0000; fi_dur = 16'd3;
      cycle();
      fi_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (fault_active) n++;
         cycle();
      end
      check("transient_len", 64'(n), 64'(3));
      #1;
      check("transient_after", 64'(rdata[31:0]), 64'h0000_00FF);

      // Committed upset with scrubbing: persistent error, one report per sweep.
      scrub_en = 1'b1;
      fi_valid = 1'b1; fi_type = 2'd1; fi_mode = 2'd2; fi_mask = 32'h2; fi_addr = 5;
      cycle();
      fi_valid = 1'b0;
      #1;
      check("commit_ready", 64'(fi_ready), 64'(0));
      cycle();
      #1;
      check("upset_rdata", 64'(rdata[31:0]), 64'h0000_00FD);
      check("upset_rperr", 64'(rperr), 64'(2'b11));
      repeat (2) cycle();
      base = scrub_err_cnt;
      n = 0;
      for (int k = 0; k < 62; k++) begin
         if (scrub_err) begin
            n++;
            check("scrub_addr5", 64'(scrub_err_addr), 64'(5));
         end
         cycle();
      end
      check("scrub_pulses", 64'(n), 64'(2));
      check("scrub_cnt_delta", 64'(scrub_err_cnt - base), 64'(2));
      we = 1'b1; waddr = 5; wdata = 32'h0000_00FF;
      cycle();
      we = 1'b0;
      repeat (2) cycle();
      base = scrub_err_cnt;
      repeat (40) cycle();
      check("scrub_cleared", 64'(scrub_err_cnt), 64'(base));

      // Fault and write aimed at r0: r0 stays zero and clean.
      fi_valid = 1'b1; fi_type = 2'd1; fi_mode = 2'd0; fi_addr = 0; fi_mask = '1;
      cycle();
      fi_valid = 1'b0;
      we = 1'b1; waddr = 0; wdata = 32'hDEAD_BEEF; set_raddr(0, 0);
      #1;
      check("r0_bypass", 64'(rdata), 64'(0));
      check("r0_rperr", 64'(rperr), 64'(0));
      cycle();
      we = 1'b0;
      cycle();
      fi_valid = 1'b1; fi_type = 2'd0;
      cycle();
      fi_valid = 1'b0;

      // Reset asserted in the middle of a long transient.
      fi_valid = 1'b1; fi_type = 2'd1; fi_mode = 2'd1; fi_addr = 5; fi_mask = 32'h1;
      fi_dur = 16'd20; set_raddr(5, 6);
      cycle();
      fi_valid = 1'b0;
      repeat (3) cycle();
      check("pre_reset_active", 64'(fault_active), 64'(1));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_active", 64'(fault_active), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_cnt", 64'(scrub_err_cnt), 64'(0));
      cycle();
      rst_n = 1'b1;

      // Randomized traffic.
      for (int k = 0; k < 700; k++) begin
         we    = ($urandom_range(0, 1) == 1);
         waddr = rand_addr();
         wdata = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255)) : $urandom;
         set_raddr(rand_addr(), rand_addr());
         fi_valid = ($urandom_range(0, 7) == 0);
         fi_addr  = rand_addr();
         fi_mask  = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
         fi_type  = 2'($urandom_range(0, 3));
         fi_mode  = 2'($urandom_range(0, 3));
         fi_dur   = 16'($urandom_range(0, 5));
         scrub_en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
